// File: rtl/pio_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pio_write_arbiter
// Brief    : Round-robin sharing of one Avalon-MM output PIO register among
//            NUM_REQ requesters, with optional read-back compare per write.
// Revision : 1.0 - initial release
// ============================================================================
module pio_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int VERIFY  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        busy,
    output logic                        mismatch,
    output logic [1:0]                  avm_address,
    output logic                        avm_chipselect,
    output logic                        avm_write_n,
    output logic [31:0]                 avm_writedata,
    input  logic [31:0]                 avm_readdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_gnt;
    logic [PTR_W-1:0]    w_gnt;
    logic                w_found;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_sel_data;

    // First set request scanning upward from the slot after the last grant
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_gnt   = r_rr_ptr;
        v_idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            v_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (!w_found && req[v_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = v_idx[PTR_W-1:0];
            end
        end
        w_sel_data = req_data[int'(w_gnt)*DATA_W +: DATA_W];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_WRITE;
            S_WRITE: w_next = (VERIFY != 0) ? S_READ : S_ACK;
            S_READ:  w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus and handshake outputs are registered decodes of the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= PTR_W'(NUM_REQ - 1);
            r_gnt          <= '0;
            r_data         <= '0;
            ack            <= '0;
            busy           <= 1'b0;
            mismatch       <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_found) begin
                r_rr_ptr <= w_gnt;
                r_gnt    <= w_gnt;
                r_data   <= w_sel_data;
            end
            avm_chipselect <= (w_next == S_WRITE) || (w_next == S_READ);
            avm_write_n    <= (w_next != S_WRITE);
            busy           <= (w_next != S_IDLE);
            ack            <= (w_next == S_ACK) ? (NUM_REQ'(1) << r_gnt) : '0;
            mismatch       <= (VERIFY != 0) && (r_state == S_READ) &&
                              (avm_readdata[DATA_W-1:0] != r_data);
        end
    end

    assign avm_address   = 2'b00;
    assign avm_writedata = 32'(r_data);

endmodule
`default_nettype wire
